// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a FIFO feeds a framing FSM that sends words back-to-back.
// Optional parity slot is compiled in when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
    parameter int CLOCK_MHZ       = 16,
    parameter int BAUD_RATE       = 115200,
    parameter int DATA_BITS       = 8,
    parameter int STOP_BITS       = 1,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int PARITY_ODD      = 0
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_write,
    input  logic [DATA_BITS-1:0]       i_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [FIFO_DEPTH_LOG2:0]   o_level,
    output logic                       o_overflow,
    output logic                       o_busy,
    output logic                       o_uart_tx
);

    localparam int CLKS_PER_BIT = (CLOCK_MHZ * 1_000_000) / BAUD_RATE;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int LW           = FIFO_DEPTH_LOG2 + 1;
    localparam int DEPTH        = 2 ** FIFO_DEPTH_LOG2;

    localparam logic [CNT_W-1:0]           CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]           CNT_ONE    = CNT_W'(1);
    localparam logic [2:0]                 DATA_LAST  = 3'(DATA_BITS - 1);
    localparam logic [2:0]                 STOP_LAST  = 3'(STOP_BITS - 1);
    localparam logic [LW-1:0]              LEVEL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0]              LEVEL_ONE  = LW'(1);
    localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE    = FIFO_DEPTH_LOG2'(1);

    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be 5..8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
        $error("uart_tx_fifo: PARITY_ODD must be 0 or 1");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic PARITY_ODD_BIT = 1'(PARITY_ODD);

    function automatic logic parity_of(input logic [DATA_BITS-1:0] word);
        return (^word) ^ PARITY_ODD_BIT;
    endfunction
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd4
    } state_t;
`endif

    logic [DATA_BITS-1:0]       mem_r [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_r;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_r;
    logic [LW-1:0]              level_r;
    logic [LW-1:0]              level_s;
    logic                       full_r;
    logic                       empty_r;
    logic                       overflow_r;
    logic                       busy_r;
    logic                       tx_r;
    logic                       push_s;
    logic                       pop_s;
    logic                       line_s;
    logic                       baud_done_s;
    logic [DATA_BITS-1:0]       head_s;

    state_t                     state_r;
    state_t                     state_s;
    logic [CNT_W-1:0]           cnt_r;
    logic [CNT_W-1:0]           cnt_s;
    logic [2:0]                 bit_r;
    logic [2:0]                 bit_s;
    logic [DATA_BITS-1:0]       shift_r;
    logic [DATA_BITS-1:0]       shift_s;
`ifdef UART_TX_PARITY_EN
    logic                       parity_r;
    logic                       parity_s;
`endif

    assign push_s      = i_write && !full_r;
    assign head_s      = mem_r[rd_ptr_r];
    assign baud_done_s = (cnt_r == CNT_LAST);

    // FIFO storage array; no reset needed since pointers gate every read
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= i_data;
        end
    end

    // Occupancy after this edge's push/pop
    always_comb begin
        level_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_s = level_r + LEVEL_ONE;
            2'b01:   level_s = level_r - LEVEL_ONE;
            default: level_s = level_r;
        endcase
    end

    // FIFO pointers, registered flags and sticky overflow
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            level_r    <= '0;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            level_r <= level_s;
            full_r  <= (level_s == LEVEL_FULL);
            empty_r <= (level_s == '0);
            if (i_write && full_r) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Framing FSM next-state, baud/bit counters and FIFO pop
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        bit_s   = bit_r;
        shift_s = shift_r;
        pop_s   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_s = parity_r;
`endif
        case (state_r)
            S_IDLE: begin
                if (!empty_r) begin
                    pop_s   = 1'b1;
                    shift_s = head_s;
`ifdef UART_TX_PARITY_EN
                    parity_s = parity_of(head_s);
`endif
                    cnt_s   = '0;
                    bit_s   = 3'd0;
                    state_s = S_START;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_START: begin
                if (baud_done_s) begin
                    cnt_s   = '0;
                    bit_s   = 3'd0;
                    state_s = S_DATA;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            S_DATA: begin
                if (baud_done_s) begin
                    cnt_s   = '0;
                    shift_s = shift_r >> 1;
                    if (bit_r == DATA_LAST) begin
                        bit_s = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_s = S_PARITY;
`else
                        state_s = S_STOP;
`endif
                    end else begin
                        bit_s = bit_r + 3'd1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_done_s) begin
                    cnt_s   = '0;
                    bit_s   = 3'd0;
                    state_s = S_STOP;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
`endif
            S_STOP: begin
                if (baud_done_s) begin
                    cnt_s = '0;
                    if (bit_r == STOP_LAST) begin
                        bit_s = 3'd0;
                        // Chain straight into the next frame so there is no idle gap
                        if (!empty_r) begin
                            pop_s   = 1'b1;
                            shift_s = head_s;
`ifdef UART_TX_PARITY_EN
                            parity_s = parity_of(head_s);
`endif
                            state_s = S_START;
                        end else begin
                            state_s = S_IDLE;
                        end
                    end else begin
                        bit_s = bit_r + 3'd1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Line level for the current state; registered below so the pin lags the state by one edge
    always_comb begin
        line_s = 1'b1;
        case (state_r)
            S_IDLE:   line_s = 1'b1;
            S_START:  line_s = 1'b0;
            S_DATA:   line_s = shift_r[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: line_s = parity_r;
`endif
            S_STOP:   line_s = 1'b1;
            default:  line_s = 1'b1;
        endcase
    end

    // FSM state, datapath and registered line/busy outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r <= S_IDLE;
            cnt_r   <= '0;
            bit_r   <= 3'd0;
            shift_r <= '0;
`ifdef UART_TX_PARITY_EN
            parity_r <= 1'b0;
`endif
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
`ifdef UART_TX_PARITY_EN
            parity_r <= parity_s;
`endif
            tx_r    <= line_s;
            busy_r  <= (state_r != S_IDLE) || !empty_r;
        end
    end

    assign o_full     = full_r;
    assign o_empty    = empty_r;
    assign o_level    = level_r;
    assign o_overflow = overflow_r;
    assign o_busy     = busy_r;
    assign o_uart_tx  = tx_r;

endmodule
